i2c_lcd_cmd_sequencer: RTL and testbench
========================================

// Module: i2c_lcd_cmd_sequencer
// PURPOSE
//  Parametrised I2C write master for the character-LCD path: START, 7-bit address + W, then a streamed
//  sequence of command/data bytes, each followed by an ACK slot, then STOP. Replaces the fixed
//  single-instruction display driver. Adds a configurable bit rate, arbitrary-length byte streams via a
//  valid/ready handshake, open-drain SDA with real ACK sampling, and NACK abort.
//  Sits between the display-init/text controller (byte source) and the LCD SDA/SCL pins.
// PARAMETERS
//  CLK_DIV     100       clk cycles per quarter-bit tick (bit period = 4*CLK_DIV); legal range 2..65535
//  SLAVE_ADDR  7'h3E     7-bit LCD address; the address byte on the wire is {SLAVE_ADDR,1'b0} = 8'h7C
//  ACK_CHECK   1         1: slave NACK aborts the transfer; 0: ACK bit is sampled but ignored
// PORTS
//  clk         in   1   system clock
//  rst         in   1   synchronous, active-high reset
//  start       in   1   begin a transaction; accepted only in IDLE, ignored while busy
//  cmd_data    in   8   next byte to send, MSB first
//  cmd_last    in   1   qualifies cmd_data: this is the final byte of the transaction
//  cmd_valid   in   1   cmd_data/cmd_last are valid
//  cmd_ready   out  1   sequencer takes a byte this cycle when cmd_valid is also high
//  sda_in      in   1   SDA pin readback (already synchronised)
//  sda_oe      out  1   1 = drive SDA low; 0 = release (pulled high externally)
//  scl         out  1   SCL level, push-pull
//  busy        out  1   high from accepted start until the STOP completes
//  done        out  1   1-cycle pulse: STOP finished after all bytes were ACKed
//  nack_err    out  1   1-cycle pulse: STOP finished after a NACK abort; mutually exclusive with done
// BEHAVIOUR
//  Reset: scl=1, sda_oe=0, cmd_ready=0, busy=0, done=0, nack_err=0, state=IDLE, tick counter=0.
//  Reset mid-transfer takes effect on the next edge: bus released immediately, no STOP is generated.
//  Tick: counter runs 0..CLK_DIV-1 only while busy; each wrap is one quarter-phase Q0..Q3.
//  Bit slot: Q0 scl=0 and set sda_oe; Q1 scl=1; Q2 scl=1, sample sda_in; Q3 scl=0. SDA changes only in Q0.
//  IDLE: scl=1, sda_oe=0. start=1 -> START, busy=1 next cycle, tick counter cleared.
//  START: Q0-Q1 sda_oe=1 with scl=1 (START condition), Q2-Q3 scl=0 -> ADDR.
//  ADDR: 8 bit slots of 8'h7C MSB first (sda_oe = ~bit) -> ACK.
//  ACK: one slot with sda_oe=0; sda_in sampled at Q2. Ack = sda_in==0.
//   NACK and ACK_CHECK=1 -> STOP with abort flag set. Otherwise: after last byte -> STOP, else -> LOAD.
//  LOAD: scl held low, sda_oe=0, cmd_ready=1, tick counter held. On cmd_valid&cmd_ready capture
//   cmd_data/cmd_last, cmd_ready=0 next cycle -> DATA. cmd_valid low: stay indefinitely (bus stretched).
//   cmd_ready is high only in LOAD; never combinationally dependent on cmd_valid.
//  DATA: 8 bit slots of captured byte MSB first -> ACK.
//  STOP: Q0 scl=0 sda_oe=1; Q1 scl=1; Q2 sda_oe=0 (STOP condition); Q3 hold -> IDLE.
//   On IDLE entry busy=0 and exactly one of done/nack_err pulses for 1 cycle.
//  First LOAD follows the address ACK, so a transaction carries >=1 data byte; no length limit.
//  start asserted during busy: ignored, not queued. start and done in same cycle: start ignored.
//  Bytes per transaction are framed solely by cmd_last; bytes after a NACK abort are not consumed.
// TESTING (CLK_DIV=4, SLAVE_ADDR=7'h3E, ACK_CHECK=1, bench slave model ACKs unless stated)
//  1 Reset: hold rst 3 cycles -> scl=1, sda_oe=0, busy=0, cmd_ready=0; start during rst ignored.
//  2 Single byte: start, bytes {8'h00,8'h0C last} -> wire shows START, 7C, A, 00, A, 0C, A, STOP;
//    each bit 16 clk; done pulses once; busy low after; decoded bytes match exactly.
//  3 Backpressure: hold cmd_valid low 200 cycles in LOAD -> scl stays 0, no tick advance; resumes on valid.
//  4 NACK: slave NACKs address -> STOP issued, nack_err=1 one cycle, done=0, cmd_ready never high.
//  5 Mid-transfer reset during 3rd data bit -> next cycle scl=1, sda_oe=0, busy=0, no pulses; new start works.
//  6 Back-to-back: start pulsed while busy ignored; re-issue one cycle after done -> second frame correct.

Source files
------------

// File: rtl/i2c_lcd_cmd_sequencer.sv
// rtl/i2c_lcd_cmd_sequencer.sv - I2C write master streaming command/data bytes to a character LCD
//
// Purpose: generates START, address byte {SLAVE_ADDR,0}, then one ACK-checked byte per
// cmd_valid/cmd_ready handshake until the byte flagged cmd_last, then STOP. A NACK (with
// ACK_CHECK=1) aborts straight to STOP and reports nack_err instead of done.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    begin a transaction (taken only while idle)
//   cmd_data/cmd_last/
//   cmd_valid/cmd_ready      byte stream from the display controller
//   sda_in                   synchronised SDA readback
//   sda_oe                   1 pulls SDA low, 0 releases it
//   scl                      push-pull SCL
//   busy, done, nack_err     status; done/nack_err are single-cycle pulses on return to idle

module i2c_lcd_cmd_sequencer #(
    parameter int         CLK_DIV    = 100,
    parameter logic [6:0] SLAVE_ADDR = 7'h3E,
    parameter bit         ACK_CHECK  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] cmd_data,
    input  logic       cmd_last,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       scl,
    output logic       busy,
    output logic       done,
    output logic       nack_err
);

    localparam logic [15:0] TICK_MAX = 16'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ACK,
        S_LOAD,
        S_DATA,
        S_STOP
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] tick_q, tick_d;
    logic [1:0]  phase_q, phase_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  byte_q, byte_d;
    logic        last_q, last_d;
    logic        abort_q, abort_d;
    logic        done_q, done_d;
    logic        nack_q, nack_d;

    logic tick_wrap;
    logic slot_end;

    assign tick_wrap = (tick_q == TICK_MAX);
    assign slot_end  = tick_wrap && (phase_q == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            phase_q <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            last_q  <= 1'b0;
            abort_q <= 1'b0;
            done_q  <= 1'b0;
            nack_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            last_q  <= last_d;
            abort_q <= abort_d;
            done_q  <= done_d;
            nack_q  <= nack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        last_d  = last_q;
        abort_d = abort_q;
        done_d  = 1'b0;
        nack_d  = 1'b0;

        // Quarter-phase timebase runs only while actively clocking the bus; LOAD freezes it
        // so a stalled byte source simply stretches SCL low.
        if (state_q != S_IDLE && state_q != S_LOAD) begin
            if (tick_wrap) begin
                tick_d  = '0;
                phase_d = phase_q + 2'd1;
            end else begin
                tick_d = tick_q + 16'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                // The done/nack_err cycle is still "idle" but a start there is dropped.
                if (start && !done_q && !nack_q) begin
                    state_d = S_START;
                    tick_d  = '0;
                    phase_d = '0;
                    bit_d   = '0;
                    byte_d  = {SLAVE_ADDR, 1'b0};
                    last_d  = 1'b0;
                    abort_d = 1'b0;
                end
            end
            S_START: begin
                if (slot_end) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR, S_DATA: begin
                if (slot_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = S_ACK;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_ACK: begin
                // Sample on the last clock of Q2, while SCL is high and settled.
                if (tick_wrap && phase_q == 2'd2 && sda_in && ACK_CHECK) begin
                    abort_d = 1'b1;
                end
                // last_q is only ever set by a captured data byte, so the address ACK
                // always proceeds to LOAD unless it was a NACK.
                if (slot_end) begin
                    state_d = (abort_q || last_q) ? S_STOP : S_LOAD;
                end
            end
            S_LOAD: begin
                if (cmd_valid) begin
                    state_d = S_DATA;
                    byte_d  = cmd_data;
                    last_d  = cmd_last;
                    bit_d   = '0;
                    tick_d  = '0;
                    phase_d = '0;
                end
            end
            S_STOP: begin
                if (slot_end) begin
                    state_d = S_IDLE;
                    done_d  = !abort_q;
                    nack_d  = abort_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        scl    = 1'b1;
        sda_oe = 1'b0;
        case (state_q)
            S_IDLE: begin
                scl    = 1'b1;
                sda_oe = 1'b0;
            end
            S_START: begin
                // SDA falls with SCL high in Q0, then SCL drops for the first bit.
                scl    = (phase_q < 2'd2);
                sda_oe = 1'b1;
            end
            S_ADDR, S_DATA: begin
                scl    = (phase_q == 2'd1) || (phase_q == 2'd2);
                sda_oe = ~byte_q[3'd7 - bit_q];
            end
            S_ACK: begin
                scl    = (phase_q == 2'd1) || (phase_q == 2'd2);
                sda_oe = 1'b0;
            end
            S_LOAD: begin
                scl    = 1'b0;
                sda_oe = 1'b0;
            end
            S_STOP: begin
                // SDA released in Q2 while SCL is high forms the STOP condition.
                scl    = (phase_q != 2'd0);
                sda_oe = (phase_q < 2'd2);
            end
            default: begin
                scl    = 1'b1;
                sda_oe = 1'b0;
            end
        endcase
    end

    assign cmd_ready = (state_q == S_LOAD);
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign nack_err  = nack_q;

endmodule

// File: tb/tb_i2c_lcd_cmd_sequencer.sv
// tb/tb_i2c_lcd_cmd_sequencer.sv - self-checking bench for i2c_lcd_cmd_sequencer

module tb_i2c_lcd_cmd_sequencer;

    localparam int CLK_DIV = 4;
    localparam int BUDGET  = 6000;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] cmd_data;
    logic       cmd_last;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       sda_oe;
    logic       scl;
    logic       busy;
    logic       done;
    logic       nack_err;
    logic       slave_low = 1'b0;
    logic       sda_line;

    assign sda_line = ~(sda_oe | slave_low);

    i2c_lcd_cmd_sequencer #(
        .CLK_DIV   (CLK_DIV),
        .SLAVE_ADDR(7'h3E),
        .ACK_CHECK (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cmd_data (cmd_data),
        .cmd_last (cmd_last),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .sda_in   (sda_line),
        .sda_oe   (sda_oe),
        .scl      (scl),
        .busy     (busy),
        .done     (done),
        .nack_err (nack_err)
    );

    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic chk(input string nm, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Bus monitor + slave: decodes START/STOP/bytes from the wire and ACKs every
    // byte except the one whose index (address = 0) equals nack_idx.
    logic [7:0] rx_q[$];
    logic [7:0] m_shift = 8'h00;
    int  m_bits = 0, m_starts = 0, m_stops = 0, m_period_err = 0;
    int  m_cyc = 0, m_last_rise = 0, nack_idx = -1;
    logic m_prev_scl = 1'b1, m_prev_sda = 1'b1;

    always @(posedge clk) begin
        m_cyc++;
        if (rst) begin
            m_bits     = 0;
            m_prev_scl = 1'b1;
            m_prev_sda = 1'b1;
            slave_low <= 1'b0;
        end else begin
            if (m_prev_scl && scl && m_prev_sda && !sda_line) begin
                m_starts++;
                m_bits = 0;
            end else if (m_prev_scl && scl && !m_prev_sda && sda_line) begin
                m_stops++;
                m_bits = 0;
            end else if (!m_prev_scl && scl) begin
                if (m_bits >= 1 && m_bits <= 8 && (m_cyc - m_last_rise) != 4 * CLK_DIV)
                    m_period_err++;
                m_last_rise = m_cyc;
                if (m_bits < 8) m_shift = {m_shift[6:0], sda_line};
                m_bits++;
                if (m_bits == 8) rx_q.push_back(m_shift);
            end else if (m_prev_scl && !scl) begin
                if (m_bits == 8) slave_low <= ((int'(rx_q.size()) - 1) != nack_idx);
                else if (m_bits == 9) begin
                    slave_low <= 1'b0;
                    m_bits = 0;
                end
            end
            m_prev_scl = scl;
            m_prev_sda = sda_line;
        end
    end

    typedef struct {
        int nb;
        int nack_at;       // byte index the slave NACKs (0 = address), -1 = none
        int gap;           // max random stall before each byte (in LOAD cycles)
        int first_gap;     // forced stall before the first data byte
        bit fixed;         // use bytes 8'h00, 8'h0C
        bit spam;          // pulse start while busy
        bit start_at_done; // drive start in the done/nack cycle
        bit exp_done;
        bit exp_nack;
    } vec_t;

    task automatic run_txn(input vec_t v);
        logic [7:0] txb[$];
        logic [7:0] expb[$];
        int  idx, wait_cnt, cycles, done_n, nack_n, ready_hi, ready_bad, n;
        bit  hs;
        for (int i = 0; i < v.nb; i++)
            txb.push_back(v.fixed ? ((i == 0) ? 8'h00 : 8'h0C) : 8'($urandom));
        // Reference: the wire carries the address, then data bytes up to and including
        // the one that was NACKed (or all of them).
        expb.push_back(8'h7C);
        if (v.nack_at != 0) begin
            for (int i = 0; i < v.nb; i++) begin
                expb.push_back(txb[i]);
                if (i + 1 == v.nack_at) break;
            end
        end

        rx_q.delete();
        m_starts = 0; m_stops = 0; m_period_err = 0;
        nack_idx = v.nack_at;
        idx = 0; wait_cnt = v.first_gap; cycles = 0;
        done_n = 0; nack_n = 0; ready_hi = 0; ready_bad = 0;

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);

        while (cycles < BUDGET) begin
            if (!cmd_valid && idx < v.nb) begin
                if (wait_cnt == 0) begin
                    cmd_valid = 1'b1;
                    cmd_data  = txb[idx];
                    cmd_last  = (idx == v.nb - 1);
                end else if (cmd_ready) begin
                    wait_cnt--;
                end
            end
            start = (v.spam && cycles == 40);
            hs = cmd_valid && cmd_ready;
            if (cmd_ready) begin
                ready_hi++;
                if (scl || sda_oe) ready_bad++;
            end
            @(posedge clk); #1;
            cycles++;
            start = 1'b0;
            if (hs) begin
                idx++;
                cmd_valid = 1'b0;
                wait_cnt  = $urandom_range(v.gap, 0);
            end
            if (done) done_n++;
            if (nack_err) nack_n++;
            if (done || nack_err) break;
        end
        cmd_valid = 1'b0;

        chk("timeout", int'(cycles < BUDGET), 1);
        chk("done_pulse", done_n, int'(v.exp_done));
        chk("nack_pulse", nack_n, int'(v.exp_nack));
        chk("busy_at_pulse", busy, 0);
        chk("byte_count", rx_q.size(), expb.size());
        n = (rx_q.size() < expb.size()) ? rx_q.size() : expb.size();
        for (int i = 0; i < n; i++) chk($sformatf("wire_byte%0d", i), rx_q[i], expb[i]);
        chk("bytes_consumed", idx, expb.size() - 1);
        chk("bit_period", m_period_err, 0);
        chk("start_conds", m_starts, 1);
        chk("stop_conds", m_stops, 1);
        chk("ready_bus_idle", ready_bad, 0);
        if (v.nack_at == 0) chk("ready_on_addr_nack", ready_hi, 0);

        start = v.start_at_done;
        @(posedge clk); #1;
        start = 1'b0;
        chk("pulse_width", int'(done | nack_err), 0);
        chk("idle_after", busy, 0);
    endtask

    vec_t vecs[$];
    vec_t rv;
    int   cyc, pulses;

    initial begin
        vecs.push_back('{2, -1, 0, 0,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{2, -1, 2, 200, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{3, 0,  0, 0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{4, 2,  1, 0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{3, -1, 0, 0,   1'b0, 1'b1, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{1, -1, 0, 0,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{2, 2,  3, 5,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1});

        rst = 1'b1; start = 1'b1;
        cmd_data = 8'h00; cmd_last = 1'b0; cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_scl", scl, 1);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        rst = 1'b0; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_start_ignored", busy, 0);
        chk("rst_no_pulse", int'(done | nack_err), 0);

        foreach (vecs[i]) run_txn(vecs[i]);

        // Reset during the third data bit of a single-byte frame.
        rx_q.delete();
        nack_idx = -1;
        cmd_data = 8'hA5; cmd_last = 1'b1; cmd_valid = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!(rx_q.size() == 1 && m_bits == 2) && cyc < BUDGET) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("midrst_reach", int'(cyc < BUDGET), 1);
        repeat (14) @(posedge clk);
        #1;
        chk("midrst_busy_before", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_scl", scl, 1);
        chk("midrst_sda_oe", sda_oe, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_pulses", int'(done | nack_err), 0);
        rst = 1'b0; cmd_valid = 1'b0;
        pulses = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done || nack_err || busy) pulses++;
        end
        chk("midrst_quiet", pulses, 0);
        run_txn(vecs[0]);

        for (int t = 0; t < 8; t++) begin
            rv.nb            = $urandom_range(5, 1);
            rv.nack_at       = ($urandom_range(3, 0) == 0) ? int'($urandom_range(rv.nb, 0)) : -1;
            rv.gap           = $urandom_range(5, 0);
            rv.first_gap     = $urandom_range(10, 0);
            rv.fixed         = 1'b0;
            rv.spam          = $urandom_range(1, 0);
            rv.start_at_done = $urandom_range(1, 0);
            rv.exp_done      = (rv.nack_at < 0);
            rv.exp_nack      = (rv.nack_at >= 0);
            run_txn(rv);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
